// File: rtl/irq_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter.
// Optional round-robin selection is enabled by defining IRQ_ARBITER_ROUND_ROBIN_EN.
package irq_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam int NSRC_DEF = 4;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Circular first-one search over the eligible sources, starting at i_start.
// With i_start tied to zero this is plain lowest-index-wins priority.
module irq_prio_sel
  import irq_arbiter_pkg::*;
#(
  parameter int NSRC  = NSRC_DEF,
  parameter int VEC_W = clog2(NSRC)
) (
  input  logic [NSRC-1:0]  i_eligible,
  input  logic [VEC_W-1:0] i_start,
  output logic             o_found,
  output logic [VEC_W-1:0] o_idx
);

  always_comb begin
    int j;
    j       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NSRC; k++) begin
      j = int'(i_start) + k;
      if (j >= NSRC) j = j - NSRC;
      if (!o_found && i_eligible[VEC_W'(j)]) begin
        o_found = 1'b1;
        o_idx   = VEC_W'(j);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Shares one CPU interrupt among NSRC level requesters with an ack/eoi handshake.
// Define IRQ_ARBITER_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int NSRC  = NSRC_DEF,
  parameter int VEC_W = clog2(NSRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NSRC-1:0]  src_irq,
  output logic [NSRC-1:0]  src_clr,
  input  logic             mask_we,
  input  logic [NSRC-1:0]  mask_wdata,
  output logic [NSRC-1:0]  mask,
  output logic [NSRC-1:0]  pending,
  output logic             irq,
  output logic [VEC_W-1:0] vec,
  input  logic             ack,
  input  logic             eoi
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NSRC-1:0]  r_src_q;
  logic [NSRC-1:0]  r_pending;
  logic [NSRC-1:0]  r_mask;
  logic [NSRC-1:0]  r_src_clr;
  logic             r_irq;
  logic [VEC_W-1:0] r_vec;

  logic [NSRC-1:0]  w_eligible;
  logic [NSRC-1:0]  w_rise;
  logic [NSRC-1:0]  w_clr_sel;
  logic [NSRC-1:0]  w_pending_nxt;
  logic             w_irq_nxt;
  logic [VEC_W-1:0] w_vec_nxt;
  logic [VEC_W-1:0] w_start;
  logic [VEC_W-1:0] w_sel_idx;
  logic             w_found;

  assign w_eligible = r_pending & r_mask;
  assign w_rise     = src_irq & ~r_src_q;

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
  logic [VEC_W-1:0] r_last_grant;
  logic [VEC_W-1:0] w_last_grant_nxt;

  // Search begins just after the most recently serviced source, wrapping at NSRC.
  assign w_start = (int'(r_last_grant) == NSRC - 1) ? '0 : r_last_grant + VEC_W'(1);
`else
  assign w_start = '0;
`endif

  irq_prio_sel #(
    .NSRC  (NSRC),
    .VEC_W (VEC_W)
  ) u_sel (
    .i_eligible (w_eligible),
    .i_start    (w_start),
    .o_found    (w_found),
    .o_idx      (w_sel_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_irq_nxt   = r_irq;
    w_vec_nxt   = r_vec;
    w_clr_sel   = '0;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
    w_last_grant_nxt = r_last_grant;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = REQ;
          w_irq_nxt   = 1'b1;
          w_vec_nxt   = w_sel_idx;
        end
      end
      REQ: begin
        // An ack is honoured even if the granted source lost its mask this cycle.
        if (ack) begin
          w_state_nxt       = SERVICE;
          w_irq_nxt         = 1'b0;
          w_clr_sel[r_vec]  = 1'b1;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
          w_last_grant_nxt  = r_vec;
`endif
        end else if (!w_eligible[r_vec]) begin
          w_state_nxt = IDLE;
          w_irq_nxt   = 1'b0;
        end
      end
      SERVICE: begin
        if (eoi) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_irq_nxt   = 1'b0;
      end
    endcase
    // A new rising edge in the clearing cycle keeps the source pending.
    w_pending_nxt = (r_pending & ~w_clr_sel) | w_rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_src_q   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_src_clr <= '0;
      r_irq     <= 1'b0;
      r_vec     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_src_q   <= src_irq;
      r_pending <= w_pending_nxt;
      r_src_clr <= w_clr_sel;
      r_irq     <= w_irq_nxt;
      r_vec     <= w_vec_nxt;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last_grant <= VEC_W'(NSRC - 1);
    else        r_last_grant <= w_last_grant_nxt;
  end
`endif

  assign src_clr = r_src_clr;
  assign mask    = r_mask;
  assign pending = r_pending;
  assign irq     = r_irq;
  assign vec     = r_vec;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: directed scenarios followed by random traffic,
// each cycle's expected outputs come from a behavioural model of the arbitration rules.
module tb_irq_arbiter;

  localparam int NSRC  = 4;
  localparam int VEC_W = 2;
  localparam int PH_WAIT  = 0;
  localparam int PH_OFFER = 1;
  localparam int PH_SERVE = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NSRC-1:0]  src_irq;
  logic [NSRC-1:0]  src_clr;
  logic             mask_we;
  logic [NSRC-1:0]  mask_wdata;
  logic [NSRC-1:0]  mask;
  logic [NSRC-1:0]  pending;
  logic             irq;
  logic [VEC_W-1:0] vec;
  logic             ack;
  logic             eoi;

  irq_arbiter #(.NSRC(NSRC), .VEC_W(VEC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_irq    (src_irq),
    .src_clr    (src_clr),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pending    (pending),
    .irq        (irq),
    .vec        (vec),
    .ack        (ack),
    .eoi        (eoi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             irq;
    logic [VEC_W-1:0] vec;
    logic [NSRC-1:0]  clr;
    logic [NSRC-1:0]  pend;
    logic [NSRC-1:0]  mask;
  } snap_t;

  snap_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [NSRC-1:0] m_pend, m_mask, m_prev, m_clr;
  logic            m_irq;
  int              m_vec;
  int              m_phase;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
  int              m_last;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NSRC-1:0] elig, input int start);
    for (int k = 0; k < NSRC; k++) begin
      if (elig[(start + k) % NSRC]) return (start + k) % NSRC;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_mask  = '0;
    m_prev  = '0;
    m_clr   = '0;
    m_irq   = 1'b0;
    m_vec   = 0;
    m_phase = PH_WAIT;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
    m_last  = NSRC - 1;
`endif
  endtask

  task automatic model_step(input logic [NSRC-1:0] s, input logic we,
                            input logic [NSRC-1:0] wd, input logic a, input logic e);
    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] np;
    int p;
    int start;
    elig  = m_pend & m_mask;
    np    = m_pend;
    m_clr = '0;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
    start = (m_last + 1) % NSRC;
`else
    start = 0;
`endif
    if (m_phase == PH_WAIT) begin
      p = pick(elig, start);
      if (p >= 0) begin
        m_phase = PH_OFFER;
        m_irq   = 1'b1;
        m_vec   = p;
      end
    end else if (m_phase == PH_OFFER) begin
      if (a) begin
        np[m_vec]    = 1'b0;
        m_clr[m_vec] = 1'b1;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
        m_last       = m_vec;
`endif
        m_phase      = PH_SERVE;
        m_irq        = 1'b0;
      end else if (!elig[m_vec]) begin
        m_phase = PH_WAIT;
        m_irq   = 1'b0;
      end
    end else begin
      if (e) m_phase = PH_WAIT;
    end
    m_pend = np | (s & ~m_prev);
    m_prev = s;
    if (we) m_mask = wd;
  endtask

  // Drive one cycle of inputs at a falling edge, predict, then move to the next falling edge.
  task automatic cycle(input logic [NSRC-1:0] s, input logic we, input logic [NSRC-1:0] wd,
                       input logic a, input logic e);
    snap_t x;
    src_irq    = s;
    mask_we    = we;
    mask_wdata = wd;
    ack        = a;
    eoi        = e;
    model_step(s, we, wd, a, e);
    x.irq  = m_irq;
    x.vec  = VEC_W'(m_vec);
    x.clr  = m_clr;
    x.pend = m_pend;
    x.mask = m_mask;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: compare DUT outputs against queued predictions after every rising edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_irq",     int'(irq),     int'(e.irq));
        chk("sb_vec",     int'(vec),     int'(e.vec));
        chk("sb_src_clr", int'(src_clr), int'(e.clr));
        chk("sb_pending", int'(pending), int'(e.pend));
        chk("sb_mask",    int'(mask),    int'(e.mask));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [NSRC-1:0] s;
    s          = '0;
    rst_n      = 1'b0;
    src_irq    = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    ack        = 1'b0;
    eoi        = 1'b0;
    model_reset();
    #12;
    chk("rst_irq",     int'(irq),     0);
    chk("rst_vec",     int'(vec),     0);
    chk("rst_src_clr", int'(src_clr), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_mask",    int'(mask),    0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single source
    cycle(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("s1_pending_e0", int'(pending), 1);
    chk("s1_irq_e0",     int'(irq),     0);
    cycle(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("s1_irq_e1", int'(irq), 1);
    chk("s1_vec_e1", int'(vec), 0);
    cycle(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("s1_clr",         int'(src_clr), 1);
    chk("s1_pending_clr", int'(pending), 0);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("s1_clr_once", int'(src_clr), 0);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Simultaneous rises
    cycle(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0);
    cycle(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("sim_vec_first", int'(vec), 1);
    cycle(4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("sim_clr_first", int'(src_clr), 2);
    cycle(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1);
    chk("sim_gap_irq", int'(irq), 0);
    cycle(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("sim_irq_second", int'(irq), 1);
    chk("sim_vec_second", int'(vec), 3);
    cycle(4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Masked pending, then unmask
    cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("mp_pending", int'(pending), 4);
    cycle(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("mp_irq_masked", int'(irq), 0);
    cycle(4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("mp_irq", int'(irq), 1);
    chk("mp_vec", int'(vec), 2);

    // Mask drop while requesting, with and without ack
    cycle(4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("md_irq_drop", int'(irq),     0);
    chk("md_pending",  int'(pending), 4);
    cycle(4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("md_irq_again", int'(irq), 1);
    cycle(4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("md_ack_wins_clr", int'(src_clr), 4);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Set/clear collision and misplaced ack/eoi
    cycle(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("col_irq", int'(irq), 1);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("col_pending_kept", int'(pending), 1);
    chk("col_clr",          int'(src_clr), 1);
    cycle(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("col_ack_in_service", int'(irq), 0);
    cycle(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1);
    cycle(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("col_irq_reassert", int'(irq), 1);
    cycle(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1);
    chk("col_eoi_in_req", int'(irq), 1);

    // Asynchronous reset in the middle of a request
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_irq",     int'(irq),     0);
    chk("arst_src_clr", int'(src_clr), 0);
    chk("arst_pending", int'(pending), 0);
    chk("arst_mask",    int'(mask),    0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    s = src_irq;

    // Random traffic; sources drop their line after being cleared
    for (int n = 0; n < 600; n++) begin
      s = s & ~m_clr;
      for (int i = 0; i < NSRC; i++) begin
        if ($urandom_range(0, 7) == 0) s[i] = ~s[i];
      end
      cycle(s, ($urandom_range(0, 9) == 0), NSRC'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end
    cycle('0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
